// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared types and helpers for the button_bank conditioner
//
// Purpose : channel FSM state encoding and counter-width helper used by
//           button_channel and button_bank.
// Ports   : none (package).

package button_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    PRESSED = 3'd2,
    LONG    = 3'd3,
    REL     = 3'd4
  } btn_state_t;

  // Width of a counter that must hold values 0 .. n-1; never narrower than 1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_channel.sv
// rtl/button_channel.sv - one push-button channel: synchroniser, debounce FSM, event pulses
//
// Purpose : conditions one already polarity-corrected button input.
// Macro   : BUTTON_BANK_AUTOREPEAT_EN adds a repeat counter that re-fires
//           long_o every REPEAT_CYCLES while the button is held in LONG.
// Ports   :
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   btn_i      raw button, 1 = pressed (asynchronous)
//   level_o    debounced pressed level
//   press_o    1-cycle pulse on accepted press
//   release_o  1-cycle pulse on accepted release
//   click_o    1-cycle pulse on release of a short press
//   long_o     1-cycle pulse when the hold reaches LONG_CYCLES (plus repeats)

module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000
`ifdef BUTTON_BANK_AUTOREPEAT_EN
  ,
  parameter int REPEAT_CYCLES   = 10000000
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic click_o,
  output logic long_o
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int HW = cnt_width(LONG_CYCLES);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);

  logic          sync_q1;
  logic          s;
  btn_state_t    state, state_nxt;
  logic          from_long, from_long_nxt;   // REL was entered from LONG
  logic [DW-1:0] dcnt, dcnt_nxt;
  logic [HW-1:0] hcnt, hcnt_nxt;
  logic          press_nxt, release_nxt, click_nxt, long_nxt;

`ifdef BUTTON_BANK_AUTOREPEAT_EN
  localparam int RW = cnt_width(REPEAT_CYCLES);
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rcnt, rcnt_nxt;
`endif

  // State register, counters, synchroniser and registered pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1   <= 1'b0;
      s         <= 1'b0;
      state     <= IDLE;
      from_long <= 1'b0;
      dcnt      <= '0;
      hcnt      <= '0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
      click_o   <= 1'b0;
      long_o    <= 1'b0;
    end else begin
      sync_q1   <= btn_i;
      s         <= sync_q1;
      state     <= state_nxt;
      from_long <= from_long_nxt;
      dcnt      <= dcnt_nxt;
      hcnt      <= hcnt_nxt;
      press_o   <= press_nxt;
      release_o <= release_nxt;
      click_o   <= click_nxt;
      long_o    <= long_nxt;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_nxt     = state;
    from_long_nxt = from_long;
    dcnt_nxt      = dcnt;
    hcnt_nxt      = hcnt;
    case (state)
      IDLE: begin
        if (s) begin
          state_nxt = ARM;
          dcnt_nxt  = DW'(1);
        end
      end
      ARM: begin
        if (!s) begin
          state_nxt = IDLE;
          dcnt_nxt  = '0;
        end else if (dcnt == D_LAST) begin
          state_nxt = PRESSED;
          dcnt_nxt  = '0;
          hcnt_nxt  = '0;
        end else begin
          dcnt_nxt = dcnt + DW'(1);
        end
      end
      PRESSED: begin
        // Reaching the long threshold wins over a simultaneous drop of s.
        if (hcnt == H_LAST) begin
          state_nxt = LONG;
        end else if (!s) begin
          state_nxt     = REL;
          from_long_nxt = 1'b0;
          dcnt_nxt      = DW'(1);
        end else begin
          hcnt_nxt = hcnt + HW'(1);
        end
      end
      LONG: begin
        if (!s) begin
          state_nxt     = REL;
          from_long_nxt = 1'b1;
          dcnt_nxt      = DW'(1);
        end
      end
      REL: begin
        if (s) begin
          state_nxt = from_long ? LONG : PRESSED;
          dcnt_nxt  = '0;
        end else if (dcnt == D_LAST) begin
          state_nxt = IDLE;
          dcnt_nxt  = '0;
        end else begin
          dcnt_nxt = dcnt + DW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        dcnt_nxt  = '0;
        hcnt_nxt  = '0;
      end
    endcase
  end

  // Pulse requests; registered above so each pulse lands one cycle after
  // the decision and lasts exactly one cycle.
  always_comb begin
    press_nxt   = (state == ARM) && s && (dcnt == D_LAST);
    release_nxt = (state == REL) && !s && (dcnt == D_LAST);
    click_nxt   = release_nxt && !from_long;
`ifdef BUTTON_BANK_AUTOREPEAT_EN
    long_nxt    = ((state == PRESSED) && (hcnt == H_LAST)) ||
                  ((state == LONG) && s && (rcnt == R_LAST));
`else
    long_nxt    = (state == PRESSED) && (hcnt == H_LAST);
`endif
  end

`ifdef BUTTON_BANK_AUTOREPEAT_EN
  // Repeat counter: runs only while held in LONG, pauses in REL,
  // and is cleared whenever the channel is (or is about to be) idle.
  always_comb begin
    rcnt_nxt = rcnt;
    if (state_nxt == IDLE) begin
      rcnt_nxt = '0;
    end else if ((state == LONG) && s) begin
      rcnt_nxt = (rcnt == R_LAST) ? '0 : rcnt + RW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt <= '0;
    end else begin
      rcnt <= rcnt_nxt;
    end
  end
`endif

  assign level_o = (state == PRESSED) || (state == LONG) || (state == REL);

endmodule

// File: rtl/button_bank.sv
// rtl/button_bank.sv - N-channel push-button conditioner (top)
//
// Purpose : applies input polarity and instantiates one independent
//           button_channel per button.
// Macro   : BUTTON_BANK_AUTOREPEAT_EN enables auto-repeat of long_o and the
//           REPEAT_CYCLES parameter.
// Ports   :
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   btn_i      [N_BTN] raw asynchronous button inputs
//   level_o    [N_BTN] debounced pressed level
//   press_o    [N_BTN] 1-cycle pulse on accepted press
//   release_o  [N_BTN] 1-cycle pulse on accepted release
//   click_o    [N_BTN] 1-cycle pulse on release of a short press
//   long_o     [N_BTN] 1-cycle pulse when a hold reaches LONG_CYCLES

module button_bank
  import button_pkg::*;
#(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int ACTIVE_HIGH     = 1
`ifdef BUTTON_BANK_AUTOREPEAT_EN
  ,
  parameter int REPEAT_CYCLES   = 10000000
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_i,
  output logic [N_BTN-1:0] level_o,
  output logic [N_BTN-1:0] press_o,
  output logic [N_BTN-1:0] release_o,
  output logic [N_BTN-1:0] click_o,
  output logic [N_BTN-1:0] long_o
);

  // Pressed is always 1 inside the channels.
  logic [N_BTN-1:0] btn_act;
  assign btn_act = (ACTIVE_HIGH != 0) ? btn_i : ~btn_i;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
`ifdef BUTTON_BANK_AUTOREPEAT_EN
      ,
      .REPEAT_CYCLES  (REPEAT_CYCLES)
`endif
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_i    (btn_act[i]),
      .level_o  (level_o[i]),
      .press_o  (press_o[i]),
      .release_o(release_o[i]),
      .click_o  (click_o[i]),
      .long_o   (long_o[i])
    );
  end

endmodule
